// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN core and its on-chip stimulus logic.
//
// Contents:
//   SNN_T, SNN_N, SNN_ALPHA  default core geometry and time-step window length
//   SNN_TA, SNN_NA           block/neuron select widths for the default geometry
//   seq_mode_t               sweep sequencer run mode
//   seq_state_t              sweep sequencer FSM state
//   addr_w()                 select width for a count (never below 1 bit)
//   max3()                   largest of three counts, used to size timers
//   decode_mode()            maps the 2-bit mode input onto seq_mode_t
package snn_pkg;

  localparam int unsigned SNN_T     = 4;
  localparam int unsigned SNN_N     = 16;
  localparam int unsigned SNN_ALPHA = 64;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  localparam int unsigned SNN_TA = addr_w(SNN_T);
  localparam int unsigned SNN_NA = addr_w(SNN_N);

  typedef enum logic [1:0] {
    SEQ_SINGLE = 2'd0,
    SEQ_BLOCK  = 2'd1,
    SEQ_ALL    = 2'd2
  } seq_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    FIRE,
    STEP,
    GAP,
    DRAIN,
    POST,
    NEXT
  } seq_state_t;

  // Reserved encoding 3 behaves as a single-target run.
  function automatic seq_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return SEQ_BLOCK;
      2'd2:    return SEQ_ALL;
      default: return SEQ_SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/spike_sweep_index.sv
// Target (block, neuron) counter for the spike sweep sequencer.
//
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   load            capture mode and the starting target for a new run
//   advance         step to the next target (ignored on the final target)
//   mode            run mode (0 single, 1 one block, 2 all blocks, 3 = single)
//   cfg_block       block used by single and one-block runs
//   cfg_neuron      neuron used by single runs
//   block, neuron   current target; hold their value after a run ends
//   last            current target is the final one of the run
module spike_sweep_index
  import snn_pkg::*;
#(
  parameter int unsigned T  = SNN_T,
  parameter int unsigned N  = SNN_N,
  parameter int unsigned TA = addr_w(T),
  parameter int unsigned NA = addr_w(N)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          load,
  input  logic          advance,
  input  logic [1:0]    mode,
  input  logic [TA-1:0] cfg_block,
  input  logic [NA-1:0] cfg_neuron,
  output logic [TA-1:0] block,
  output logic [NA-1:0] neuron,
  output logic          last
);

  localparam logic [TA-1:0] BLOCK_LAST  = TA'(T - 1);
  localparam logic [NA-1:0] NEURON_LAST = NA'(N - 1);

  seq_mode_t mode_q;
  seq_mode_t load_mode;

  always_comb load_mode = decode_mode(mode);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mode_q <= SEQ_SINGLE;
      block  <= '0;
      neuron <= '0;
    end else if (load) begin
      mode_q <= load_mode;
      case (load_mode)
        SEQ_SINGLE: begin
          block  <= cfg_block;
          neuron <= cfg_neuron;
        end
        SEQ_BLOCK: begin
          block  <= cfg_block;
          neuron <= '0;
        end
        default: begin
          block  <= '0;
          neuron <= '0;
        end
      endcase
    end else if (advance && !last) begin
      // Only an all-blocks sweep can reach the neuron wrap without being last.
      if (neuron == NEURON_LAST) begin
        neuron <= '0;
        block  <= block + TA'(1);
      end else begin
        neuron <= neuron + NA'(1);
      end
    end
  end

  always_comb begin
    last = 1'b1;
    case (mode_q)
      SEQ_SINGLE: last = 1'b1;
      SEQ_BLOCK:  last = (neuron == NEURON_LAST);
      default:    last = (block == BLOCK_LAST) && (neuron == NEURON_LAST);
    endcase
  end

endmodule

// File: rtl/spike_sweep_sequencer.sv
// On-chip stimulus sequencer for the SNN core.
//
// For each target (block, neuron): settle, fire one forced spike, hold
// time_step for STEPS windows of ALPHA cycles, settle, drain the core's
// output stream until tlast, settle, then move to the next target. Runs one
// target, one block, or every block and neuron.
//
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   start                         pulse that begins a run (ignored while busy)
//   abort                         synchronous stop; wins over start
//   mode                          0 single, 1 sweep cfg_block, 2 sweep all, 3 = 0
//   cfg_block, cfg_neuron         starting target for modes 0/1
//   busy                          run in progress
//   done                          one-cycle pulse on normal completion
//   force_spike_en                forced-spike strobe
//   force_spike_block_select      target block
//   force_spike_neuron_select     target neuron
//   time_step                     time-step enable to the core
//   out_tvalid, out_tlast         core output stream
//   out_tready                    ready to the core output stream (DRAIN only)
//   beat_count                    beats drained in the latest test (saturating)
//   test_index                    tests completed in the current run (saturating)
//   timeout_err                   sticky drain watchdog flag (SPIKE_SWEEP_TIMEOUT_EN only)
//
// Build option: define SPIKE_SWEEP_TIMEOUT_EN to add a DRAIN watchdog of
// TIMEOUT cycles and the timeout_err output. Without it DRAIN waits for tlast.
module spike_sweep_sequencer
  import snn_pkg::*;
#(
  parameter  int unsigned T       = SNN_T,
  parameter  int unsigned N       = SNN_N,
  parameter  int unsigned ALPHA   = SNN_ALPHA,
  parameter  int unsigned STEPS   = 1,
  parameter  int unsigned SETTLE  = 8,
  parameter  int unsigned TIMEOUT = 2 * ALPHA,
  localparam int unsigned TA      = addr_w(T),
  localparam int unsigned NA      = addr_w(N)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [TA-1:0] cfg_block,
  input  logic [NA-1:0] cfg_neuron,
  output logic          busy,
  output logic          done,
  output logic          force_spike_en,
  output logic [TA-1:0] force_spike_block_select,
  output logic [NA-1:0] force_spike_neuron_select,
  output logic          time_step,
  input  logic          out_tvalid,
  input  logic          out_tlast,
  output logic          out_tready,
  output logic [15:0]   beat_count,
  output logic [15:0]   test_index
`ifdef SPIKE_SWEEP_TIMEOUT_EN
  ,
  output logic          timeout_err
`endif
);

  localparam int unsigned CW = $clog2(max3(ALPHA, SETTLE, TIMEOUT) + 1);
  localparam int unsigned WW = addr_w(STEPS);

  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE - 1);
  localparam logic [CW-1:0] ALPHA_END  = CW'(ALPHA - 1);
  localparam logic [WW-1:0] WIN_END    = WW'(STEPS - 1);
`ifdef SPIKE_SWEEP_TIMEOUT_EN
  localparam logic [CW-1:0] DRAIN_END  = CW'(TIMEOUT - 1);
`endif

  seq_state_t    state;
  logic [CW-1:0] cnt;
  logic [WW-1:0] win;

  logic go;
  logic idx_adv;
  logic idx_last;

  // A start is only taken from IDLE, and never alongside abort.
  always_comb go      = (state == IDLE) && start && !abort;
  always_comb idx_adv = (state == NEXT) && !abort;

  spike_sweep_index #(
    .T  (T),
    .N  (N),
    .TA (TA),
    .NA (NA)
  ) u_index (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .load       (go),
    .advance    (idx_adv),
    .mode       (mode),
    .cfg_block  (cfg_block),
    .cfg_neuron (cfg_neuron),
    .block      (force_spike_block_select),
    .neuron     (force_spike_neuron_select),
    .last       (idx_last)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      cnt        <= '0;
      win        <= '0;
      done       <= 1'b0;
      beat_count <= '0;
      test_index <= '0;
`ifdef SPIKE_SWEEP_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (go) begin
              state      <= PRE;
              cnt        <= '0;
              test_index <= '0;
`ifdef SPIKE_SWEEP_TIMEOUT_EN
              timeout_err <= 1'b0;
`endif
            end
          end
          PRE: begin
            if (cnt == SETTLE_END) begin
              state <= FIRE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          FIRE: begin
            // FIRE is the first cycle of window 0, so STEP resumes at 1.
            state <= STEP;
            cnt   <= CW'(1);
            win   <= '0;
          end
          STEP: begin
            if (cnt == ALPHA_END) begin
              cnt <= '0;
              if (win == WIN_END) begin
                state <= GAP;
              end else begin
                win <= win + WW'(1);
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          GAP: begin
            if (cnt == SETTLE_END) begin
              state      <= DRAIN;
              cnt        <= '0;
              beat_count <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DRAIN: begin
            if (out_tvalid && beat_count != 16'hFFFF) begin
              beat_count <= beat_count + 16'd1;
            end
            if (out_tvalid && out_tlast) begin
              state <= POST;
              cnt   <= '0;
            end
`ifdef SPIKE_SWEEP_TIMEOUT_EN
            else if (cnt == DRAIN_END) begin
              timeout_err <= 1'b1;
              state       <= POST;
              cnt         <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
`endif
          end
          POST: begin
            if (cnt == SETTLE_END) begin
              state <= NEXT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          NEXT: begin
            if (test_index != 16'hFFFF) begin
              test_index <= test_index + 16'd1;
            end
            if (idx_last) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= PRE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    busy           = (state != IDLE);
    force_spike_en = (state == FIRE);
    time_step      = (state == FIRE) || (state == STEP);
    out_tready     = (state == DRAIN);
  end

endmodule

// File: tb/tb_spike_sweep_sequencer.sv
`timescale 1ns/1ps
module tb_spike_sweep_sequencer;

  localparam int T       = 4;
  localparam int N       = 16;
  localparam int ALPHA   = 64;
  localparam int STEPS   = 3;
  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 128;
  localparam int TA      = 2;
  localparam int NA      = 4;
  localparam int SA      = STEPS * ALPHA;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = '0;
  logic [TA-1:0] cfg_block = '0;
  logic [NA-1:0] cfg_neuron = '0;
  logic          out_tvalid = 1'b0;
  logic          out_tlast = 1'b0;
  logic          busy, done, force_spike_en, time_step, out_tready;
  logic [TA-1:0] fsb;
  logic [NA-1:0] fsn;
  logic [15:0]   beat_count, test_index;
`ifdef SPIKE_SWEEP_TIMEOUT_EN
  logic          timeout_err;
`endif

  always #5 aclk = ~aclk;

  spike_sweep_sequencer #(
    .T(T), .N(N), .ALPHA(ALPHA), .STEPS(STEPS), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .start(start),
    .abort(abort),
    .mode(mode),
    .cfg_block(cfg_block),
    .cfg_neuron(cfg_neuron),
    .busy(busy),
    .done(done),
    .force_spike_en(force_spike_en),
    .force_spike_block_select(fsb),
    .force_spike_neuron_select(fsn),
    .time_step(time_step),
    .out_tvalid(out_tvalid),
    .out_tlast(out_tlast),
    .out_tready(out_tready),
    .beat_count(beat_count),
    .test_index(test_index)
`ifdef SPIKE_SWEEP_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference-model values that persist across runs.
  int exp_beat = 0;
  int exp_tidx = 0;
  int exp_terr = 0;

  typedef struct {
    logic [1:0] mode;
    int blk;
    int nrn;
    int beats;      // 0 = random beat count per test
    int exp_tests;
    int exp_blk;
    int exp_nrn;
  } vec_t;
  vec_t tbl[6];

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  endtask

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, act, exp);
      if (n_mis >= 40) summary();
    end
  endtask

  task automatic chk_all(input int c, input bit e_busy, input bit e_done, input bit e_force,
                         input bit e_ts, input bit e_trdy, input int e_blk, input int e_nrn);
    chk("busy", c, busy, e_busy);
    chk("done", c, done, e_done);
    chk("force_spike_en", c, force_spike_en, e_force);
    chk("time_step", c, time_step, e_ts);
    chk("out_tready", c, out_tready, e_trdy);
    chk("block_select", c, fsb, e_blk);
    chk("neuron_select", c, fsn, e_nrn);
    chk("beat_count", c, beat_count, exp_beat);
    chk("test_index", c, test_index, exp_tidx);
`ifdef SPIKE_SWEEP_TIMEOUT_EN
    chk("timeout_err", c, timeout_err, exp_terr);
`endif
  endtask

  // One run, checked cycle by cycle against a timeline derived from the
  // target list: fire at f, time_step over [f, f+SA), drain from d0 until the
  // model sees the tlast handshake at l; the next target fires 2*SETTLE+2
  // cycles after l, or done appears SETTLE+2 cycles after the final l.
  // stop_kind 1: abort 10 cycles into STEP of test stop_k.
  // stop_kind 2: reset 3 cycles into DRAIN of test stop_k (returns in reset).
  task automatic run(input logic [1:0] m, input int b, input int n, input int fixed_beats,
                     input int stop_k, input int stop_kind, input bit no_tlast);
    int tq_b[$];
    int tq_n[$];
    int c, k, f, d0, l, hs, target;
    bit last;
    case (m)
      2'd1: for (int i = 0; i < N; i++) begin tq_b.push_back(b); tq_n.push_back(i); end
      2'd2: for (int bb = 0; bb < T; bb++)
              for (int i = 0; i < N; i++) begin tq_b.push_back(bb); tq_n.push_back(i); end
      default: begin tq_b.push_back(b); tq_n.push_back(n); end
    endcase
    start = 1'b1; abort = 1'b0; mode = m;
    cfg_block = TA'(b); cfg_neuron = NA'(n);
    c = 0; k = 0; f = SETTLE; d0 = f + SA + SETTLE; l = -1; hs = 0; target = 1; last = 0;
    exp_tidx = 0; exp_terr = 0;
    forever begin
      @(negedge aclk);
      if (l >= 0 && c == l + SETTLE + 2) begin
        exp_tidx++;
        if (k == tq_b.size() - 1) last = 1;
        else begin k++; f = c + SETTLE; d0 = f + SA + SETTLE; l = -1; end
      end
      if (c == d0) begin
        exp_beat = 0; hs = 0;
        target = (fixed_beats > 0) ? fixed_beats : int'($urandom_range(1, 20));
      end
      chk_all(c, !last, last, !last && c == f, c >= f && c < f + SA, c >= d0 && l < 0,
              tq_b[k], tq_n[k]);
      if (last) begin
        start = 1'b0; out_tvalid = 1'b0; out_tlast = 1'b0;
        @(negedge aclk); c++;
        chk("done_single_pulse", c, done, 0);
        chk("busy_after_done", c, busy, 0);
        chk("block_hold", c, fsb, tq_b[k]);
        chk("neuron_hold", c, fsn, tq_n[k]);
        return;
      end
      if (stop_kind == 1 && k == stop_k && c == f + 10) begin
        abort = 1'b1; start = 1'b0; out_tvalid = 1'b0;
        @(negedge aclk); c++;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
          chk_all(c, 0, 0, 0, 0, 0, tq_b[k], tq_n[k]);
          @(negedge aclk); c++;
        end
        return;
      end
      if (stop_kind == 2 && k == stop_k && c == d0 + 3) begin
        aresetn = 1'b0;
        #1;
        exp_beat = 0; exp_tidx = 0; exp_terr = 0;
        chk_all(c, 0, 0, 0, 0, 0, 0, 0);
        return;
      end
      // A start while busy must be ignored.
      start = (c == 3);
      if (c == 3) begin
        mode = 2'($urandom_range(0, 3));
        cfg_block = TA'($urandom_range(0, T - 1));
        cfg_neuron = NA'($urandom_range(0, N - 1));
      end
      if (c >= d0 && l < 0) begin
        out_tvalid = ($urandom_range(0, 3) != 0) || (c - d0 > 40);
        out_tlast = out_tvalid && !no_tlast && (hs == target - 1);
        if (out_tvalid) begin
          hs++;
          if (exp_beat < 65535) exp_beat++;
          if (out_tlast) l = c;
        end
`ifdef SPIKE_SWEEP_TIMEOUT_EN
        if (l < 0 && c - d0 == TIMEOUT - 1) begin l = c; exp_terr = 1; end
`endif
      end else begin
        // Outside DRAIN the core may wiggle freely (tlast even without tvalid).
        out_tvalid = 1'($urandom_range(0, 1));
        out_tlast = no_tlast ? 1'b0 : 1'($urandom_range(0, 1));
      end
      c++;
      if (c > 60000) begin
        n_cmp++; n_mis++;
        $display("FAIL run_budget cyc=%0d got=running want=finished", c);
        summary();
      end
    end
  endtask

  initial begin
    tbl[0] = '{2'd0, 2, 5, 16, 1, 2, 5};
    tbl[1] = '{2'd3, 1, 9, 0, 1, 1, 9};
    tbl[2] = '{2'd1, 3, 7, 0, 16, 3, 15};
    tbl[3] = '{2'd2, 1, 3, 0, 64, 3, 15};
    tbl[4] = '{2'd0, 3, 15, 0, 1, 3, 15};
    tbl[5] = '{2'd1, 0, 0, 0, 16, 0, 15};

    repeat (3) @(negedge aclk);
    chk_all(0, 0, 0, 0, 0, 0, 0, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk_all(1, 0, 0, 0, 0, 0, 0, 0);

    // start and abort together: start dropped, nothing loaded.
    start = 1'b1; abort = 1'b1; mode = 2'd0; cfg_block = 2'd3; cfg_neuron = 4'd9;
    @(negedge aclk);
    start = 1'b0; abort = 1'b0;
    chk_all(2, 0, 0, 0, 0, 0, 0, 0);
    @(negedge aclk);
    chk_all(3, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      run(tbl[i].mode, tbl[i].blk, tbl[i].nrn, tbl[i].beats, -1, 0, 1'b0);
      chk("tbl_tests", i, test_index, tbl[i].exp_tests);
      chk("tbl_block", i, fsb, tbl[i].exp_blk);
      chk("tbl_neuron", i, fsn, tbl[i].exp_nrn);
      if (tbl[i].beats > 0) chk("tbl_beats", i, beat_count, tbl[i].beats);
    end

    // Abort in STEP of the fifth test of a full sweep, then a normal run.
    run(2'd2, 0, 0, 0, 4, 1, 1'b0);
    chk("abort_test_index", 0, test_index, 4);
    run(2'd0, 1, 7, 0, -1, 0, 1'b0);
    chk("after_abort_tests", 0, test_index, 1);

    // Reset mid-DRAIN; stream activity afterwards must not be counted.
    run(2'd0, 2, 3, 0, 0, 2, 1'b0);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      out_tvalid = 1'b1;
      out_tlast = 1'($urandom_range(0, 1));
      @(negedge aclk);
      chk("post_reset_beats", i, beat_count, 0);
      chk("post_reset_busy", i, busy, 0);
      chk("post_reset_tready", i, out_tready, 0);
      chk("post_reset_tidx", i, test_index, 0);
    end
    run(2'd0, 3, 2, 0, -1, 0, 1'b0);
    chk("post_reset_run", 0, test_index, 1);

`ifdef SPIKE_SWEEP_TIMEOUT_EN
    // Core never sends tlast: watchdog ends the drain and the run completes.
    run(2'd0, 0, 1, 0, -1, 0, 1'b1);
    chk("timeout_sticky", 0, timeout_err, 1);
    run(2'd0, 1, 1, 0, -1, 0, 1'b0);
    chk("timeout_cleared", 0, timeout_err, 0);
`endif

    summary();
  end

endmodule
